sobel_stream_driver: RTL and testbench

Front/back-end adapter that drives the Sobel edge-detection core from Avalon-ST. Accepts one image frame on an Avalon-ST sink, issues the core's start pulse, writes pixels into the core, then reads the filtered results and emits them as an Avalon-ST packet with downstream backpressure. Sits between the NIOS-side streaming fabric and the Sobel core.

---
 rtl/sobel_pkg.sv | 25 ++
 rtl/sobel_skid_buf.sv | 56 +++++
 rtl/sobel_stream_driver.sv | 151 +++++++++++++++
 tb/tb_sobel_stream_driver.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and sizing helpers for the Sobel stream driver.
package sobel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_ARM,
    ST_FEED,
    ST_PAD,
    ST_COLLECT
  } state_e;

  function automatic int unsigned n_in(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction

  function automatic int unsigned n_out(input int unsigned w, input int unsigned h);
    return (w - 2) * (h - 2);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sobel_skid_buf.sv
// Two-entry registered FIFO holding {sop, eop, data} results ahead of the source port.
module sobel_skid_buf #(
  parameter int unsigned W = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [W-1:0] mem_q [2];
  logic [W-1:0] mem_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_push  = push_i & (cnt_q != 2'd2);
    do_pop   = pop_i & (cnt_q != 2'd0);
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, do_push} - {1'b0, do_pop};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign empty_o = (cnt_q == 2'd0);
  assign full_o  = (cnt_q == 2'd2);
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/sobel_stream_driver.sv
// Avalon-ST adapter: frames pixels into the Sobel core and streams its results out as one packet.
module sobel_stream_driver
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16,
  parameter int unsigned PIX_W = 8,
  parameter int unsigned RES_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             snk_valid_i,
  input  logic             snk_sop_i,
  input  logic             snk_eop_i,
  input  logic [PIX_W-1:0] snk_data_i,
  output logic             snk_ready_o,
  output logic             src_valid_o,
  output logic             src_sop_o,
  output logic             src_eop_o,
  output logic [RES_W-1:0] src_data_o,
  input  logic             src_ready_i,
  input  logic             core_ready_i,
  output logic             core_start_o,
  output logic [PIX_W-1:0] core_pix_o,
  output logic             core_pix_we_o,
  input  logic             core_res_valid_i,
  input  logic [RES_W-1:0] core_res_i,
  output logic             core_res_ack_o,
  output logic             err_o
);

  localparam int unsigned N_IN   = n_in(IMG_W, IMG_H);
  localparam int unsigned N_OUT  = n_out(IMG_W, IMG_H);
  localparam int unsigned IN_CW  = cnt_w(N_IN);
  localparam int unsigned OUT_CW = cnt_w(N_OUT);
  localparam logic [IN_CW-1:0]  IN_LAST  = IN_CW'(N_IN - 1);
  localparam logic [OUT_CW-1:0] OUT_LAST = OUT_CW'(N_OUT - 1);
  localparam logic [OUT_CW-1:0] OUT_END  = OUT_CW'(N_OUT);

  state_e              state_q, state_d;
  logic [IN_CW-1:0]    in_cnt_q, in_cnt_d;
  logic [OUT_CW-1:0]   out_cnt_q, out_cnt_d;
  logic                discard_q, discard_d;
  logic                err_q, err_d;
  logic                push, pop, skid_full, skid_empty;
  logic [RES_W+1:0]    skid_in, skid_head;

  always_comb begin
    state_d        = state_q;
    in_cnt_d       = in_cnt_q;
    out_cnt_d      = out_cnt_q;
    discard_d      = discard_q;
    err_d          = 1'b0;
    snk_ready_o    = 1'b0;
    core_start_o   = 1'b0;
    core_pix_o     = '0;
    core_pix_we_o  = 1'b0;
    core_res_ack_o = 1'b0;
    push           = 1'b0;
    pop            = src_valid_o & src_ready_i;
    skid_in        = {(out_cnt_q == '0), (out_cnt_q == OUT_LAST), core_res_i};
    unique case (state_q)
      ST_IDLE: begin
        // A discard left over from an overlong frame keeps draining until its eop.
        if (discard_q) begin
          snk_ready_o = snk_valid_i;
          if (snk_valid_i & snk_eop_i) discard_d = 1'b0;
        end else begin
          snk_ready_o = snk_valid_i & ~snk_sop_i;
          if (snk_valid_i & snk_sop_i & core_ready_i) state_d = ST_START;
        end
      end
      ST_START: begin
        core_start_o = 1'b1;
        in_cnt_d     = '0;
        out_cnt_d    = '0;
        state_d      = ST_ARM;
      end
      ST_ARM: state_d = ST_FEED;
      ST_FEED: begin
        snk_ready_o = 1'b1;
        if (snk_valid_i) begin
          core_pix_o    = snk_data_i;
          core_pix_we_o = 1'b1;
          in_cnt_d      = in_cnt_q + IN_CW'(1);
          if (in_cnt_q == IN_LAST) begin
            state_d = ST_COLLECT;
            if (!snk_eop_i) begin
              err_d     = 1'b1;
              discard_d = 1'b1;
            end
          end else if (snk_eop_i) begin
            err_d   = 1'b1;
            state_d = ST_PAD;
          end
          if (snk_sop_i && in_cnt_q != '0) err_d = 1'b1;
        end
      end
      ST_PAD: begin
        core_pix_we_o = 1'b1;
        in_cnt_d      = in_cnt_q + IN_CW'(1);
        if (in_cnt_q == IN_LAST) state_d = ST_COLLECT;
      end
      ST_COLLECT: begin
        snk_ready_o = discard_q;
        if (discard_q & snk_valid_i & snk_eop_i) discard_d = 1'b0;
        if (core_res_valid_i && !skid_full && out_cnt_q != OUT_END) begin
          core_res_ack_o = 1'b1;
          push           = 1'b1;
          out_cnt_d      = out_cnt_q + OUT_CW'(1);
        end
        if (pop & src_eop_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      discard_q <= discard_d;
      err_q     <= err_d;
    end
  end

  sobel_skid_buf #(
    .W(RES_W + 2)
  ) u_skid (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (skid_in),
    .pop_i   (pop),
    .data_o  (skid_head),
    .full_o  (skid_full),
    .empty_o (skid_empty)
  );

  assign src_valid_o                          = ~skid_empty;
  assign {src_sop_o, src_eop_o, src_data_o}   = skid_head;
  assign err_o                                = err_q;

endmodule

// File: tb/tb_sobel_stream_driver.sv
// Directed bench for sobel_stream_driver on a 4x4 image with a behavioural core model.
module tb_sobel_stream_driver;

  localparam int unsigned W  = 4;
  localparam int unsigned H  = 4;
  localparam int unsigned PW = 8;
  localparam int unsigned RW = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          snk_valid_i, snk_sop_i, snk_eop_i;
  logic [PW-1:0] snk_data_i;
  logic          snk_ready_o;
  logic          src_valid_o, src_sop_o, src_eop_o;
  logic [RW-1:0] src_data_o;
  logic          src_ready_i;
  logic          core_ready_i;
  logic          core_start_o;
  logic [PW-1:0] core_pix_o;
  logic          core_pix_we_o;
  logic          core_res_valid_i;
  logic [RW-1:0] core_res_i;
  logic          core_res_ack_o;
  logic          err_o;

  always #5 clk_i = ~clk_i;

  sobel_stream_driver #(
    .IMG_W(W),
    .IMG_H(H),
    .PIX_W(PW),
    .RES_W(RW)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .snk_valid_i      (snk_valid_i),
    .snk_sop_i        (snk_sop_i),
    .snk_eop_i        (snk_eop_i),
    .snk_data_i       (snk_data_i),
    .snk_ready_o      (snk_ready_o),
    .src_valid_o      (src_valid_o),
    .src_sop_o        (src_sop_o),
    .src_eop_o        (src_eop_o),
    .src_data_o       (src_data_o),
    .src_ready_i      (src_ready_i),
    .core_ready_i     (core_ready_i),
    .core_start_o     (core_start_o),
    .core_pix_o       (core_pix_o),
    .core_pix_we_o    (core_pix_we_o),
    .core_res_valid_i (core_res_valid_i),
    .core_res_i       (core_res_i),
    .core_res_ack_o   (core_res_ack_o),
    .err_o            (err_o)
  );

  // Core model and event recorder
  logic          clr;
  logic          stall_mode;
  logic          tog;
  int            cyc = 0;
  int            wr_cnt, wr_zero, wr_sum, starts, errs, acks, pops, res_idx;
  int            stall_err, ovf_err, first_start, first_wr;
  logic [RW-1:0] pop_data [8];
  logic [1:0]    pop_flags [8];
  logic          hold_v;
  logic [RW+2:0] hold_val;

  assign core_res_valid_i = (wr_cnt >= 16) && (res_idx < 4);
  assign core_res_i       = 8'h40 + 8'(res_idx * 3);
  assign src_ready_i      = stall_mode ? tog : 1'b1;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (clr) begin
      wr_cnt <= 0; wr_zero <= 0; wr_sum <= 0; starts <= 0; errs <= 0;
      acks <= 0; pops <= 0; res_idx <= 0; stall_err <= 0; ovf_err <= 0;
      first_start <= -1; first_wr <= -1; hold_v <= 1'b0; hold_val <= '0; tog <= 1'b0;
    end else begin
      tog <= ~tog;
      if (core_pix_we_o) begin
        wr_cnt <= wr_cnt + 1;
        wr_sum <= wr_sum + int'(core_pix_o);
        if (core_pix_o == '0) wr_zero <= wr_zero + 1;
        if (first_wr < 0) first_wr <= cyc;
      end
      if (core_start_o) begin
        starts <= starts + 1;
        if (first_start < 0) first_start <= cyc;
      end
      if (err_o) errs <= errs + 1;
      if (core_res_ack_o) begin
        acks    <= acks + 1;
        res_idx <= res_idx + 1;
      end
      if (src_valid_o & src_ready_i) begin
        if (pops < 8) begin
          pop_data[pops]  <= src_data_o;
          pop_flags[pops] <= {src_sop_o, src_eop_o};
        end
        pops <= pops + 1;
      end
      if ((acks + int'(core_res_ack_o)) - (pops + int'(src_valid_o & src_ready_i)) > 2)
        ovf_err <= ovf_err + 1;
      if (hold_v && {src_valid_o, src_sop_o, src_eop_o, src_data_o} != hold_val)
        stall_err <= stall_err + 1;
      hold_v   <= src_valid_o & ~src_ready_i;
      hold_val <= {src_valid_o, src_sop_o, src_eop_o, src_data_o};
    end
  end

  int chk_total = 0;
  int chk_pass  = 0;
  int sop_cyc;

  task automatic check(input string tag, input int got, input int exp);
    chk_total++;
    if (got == exp) chk_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int all_outs();
    return int'({snk_ready_o, src_valid_o, src_sop_o, src_eop_o, src_data_o,
                 core_start_o, core_pix_o, core_pix_we_o, core_res_ack_o, err_o});
  endfunction

  task automatic clear_model();
    clr = 1'b1;
    @(posedge clk_i); #1;
    clr = 1'b0;
  endtask

  task automatic send_beat(input logic [PW-1:0] d, input logic sop, input logic eop);
    logic r;
    int   t;
    t           = 0;
    snk_valid_i = 1'b1;
    snk_data_i  = d;
    snk_sop_i   = sop;
    snk_eop_i   = eop;
    forever begin
      @(negedge clk_i);
      r = snk_ready_o;
      @(posedge clk_i); #1;
      if (r) break;
      t++;
      if (t > 100) begin
        check("beat_accept_timeout", 0, 1);
        break;
      end
    end
    snk_valid_i = 1'b0;
    snk_sop_i   = 1'b0;
    snk_eop_i   = 1'b0;
  endtask

  task automatic send_frame(input int n, input int eop_at);
    for (int i = 1; i <= n; i++) begin
      if (i == 1) sop_cyc = cyc;
      send_beat(PW'(i), i == 1, i == eop_at);
    end
  endtask

  task automatic wait_results(input string tag);
    for (int t = 0; t < 200 && pops < 4; t++) @(posedge clk_i);
    repeat (3) @(posedge clk_i);
    #1;
    check({tag, "_pops"}, pops, 4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_data%0d", tag, k), int'(pop_data[k]), 'h40 + 3 * k);
      check($sformatf("%s_flags%0d", tag, k), int'(pop_flags[k]),
            (k == 0) ? 2 : ((k == 3) ? 1 : 0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running");
    $fatal(1);
  end

  initial begin
    rst_i = 1'b1; clr = 1'b1; stall_mode = 1'b0; core_ready_i = 1'b1;
    snk_valid_i = 1'b0; snk_sop_i = 1'b0; snk_eop_i = 1'b0; snk_data_i = '0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("reset_outputs", all_outs(), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_model();

    // Clean 16-beat frame
    send_frame(16, 16);
    wait_results("full");
    check("full_writes", wr_cnt, 16);
    check("full_sum", wr_sum, 136);
    check("full_starts", starts, 1);
    check("full_errs", errs, 0);
    check("start_latency", first_start - sop_cyc, 1);
    check("first_write_latency", first_wr - sop_cyc, 3);

    // Junk before sop
    clear_model();
    for (int i = 0; i < 3; i++) send_beat(8'hEE, 1'b0, 1'b0);
    check("junk_writes", wr_cnt, 0);
    check("junk_starts", starts, 0);
    send_frame(16, 16);
    wait_results("junk");
    check("junk_frame_writes", wr_cnt, 16);
    check("junk_errs", errs, 0);

    // Early eop on beat 10
    clear_model();
    send_frame(10, 10);
    wait_results("short");
    check("short_writes", wr_cnt, 16);
    check("short_pad_zeros", wr_zero, 6);
    check("short_sum", wr_sum, 55);
    check("short_errs", errs, 1);

    // Overlong frame of 20 beats
    clear_model();
    send_frame(20, 20);
    wait_results("long");
    check("long_writes", wr_cnt, 16);
    check("long_sum", wr_sum, 136);
    check("long_errs", errs, 1);

    // Downstream backpressure toggling every cycle
    clear_model();
    stall_mode = 1'b1;
    send_frame(16, 16);
    wait_results("stall");
    check("stall_acks", acks, 4);
    check("stall_hold", stall_err, 0);
    check("stall_overflow", ovf_err, 0);
    stall_mode = 1'b0;

    // Reset mid-frame after 7 pixels
    clear_model();
    for (int i = 1; i <= 7; i++) send_beat(PW'(i), i == 1, 1'b0);
    check("pre_reset_writes", wr_cnt, 7);
    #2 rst_i = 1'b1;
    #1 check("async_reset_outputs", all_outs(), 0);
    @(negedge clk_i);
    check("held_reset_outputs", all_outs(), 0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_model();
    send_frame(16, 16);
    wait_results("after_rst");
    check("after_rst_writes", wr_cnt, 16);
    check("after_rst_sum", wr_sum, 136);
    check("after_rst_starts", starts, 1);
    check("after_rst_errs", errs, 0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
